// File: rtl/neuron_pkg.sv
// Shared neuron datapath definitions: FP32 layout, constants and the accumulator state encoding.
package neuron_pkg;

  localparam int unsigned FP32_W      = 32;
  localparam int unsigned FP32_SIGN_W = 1;
  localparam int unsigned FP32_EXP_W  = 8;
  localparam int unsigned FP32_MAN_W  = 23;
  localparam int unsigned FP32_BIAS   = 127;

  localparam logic [FP32_W-1:0] FP32_ZERO = 32'h0000_0000;
  localparam logic [FP32_W-1:0] FP32_MAX  = 32'h7F7F_FFFF;
  localparam logic [FP32_W-1:0] FP32_ONE  = 32'h3F80_0000;

  typedef struct packed {
    logic [FP32_SIGN_W-1:0] sign;
    logic [FP32_EXP_W-1:0]  exponent;
    logic [FP32_MAN_W-1:0]  mantissa;
  } fp32_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_CMP  = 2'd2,
    ST_DONE = 2'd3
  } acc_state_e;

endpackage

// File: rtl/membrane_accumulator_if.sv
// Start/weight/result signal bundle between the neuron sequencer and membrane_accumulator.
interface membrane_accumulator_if;
  import neuron_pkg::*;

  logic              start;
  logic              has_weights;
  logic [FP32_W-1:0] decayed_potential;
  logic [FP32_W-1:0] threshold;
  logic [FP32_W-1:0] reset_potential;
  logic              weight_valid;
  logic [FP32_W-1:0] weight;
  logic              weight_last;
  logic              weight_ready;
  logic              busy;
  logic              spike;
  logic              done;
  logic [FP32_W-1:0] new_potential;

  modport master (
    output start, has_weights, decayed_potential, threshold, reset_potential,
    output weight_valid, weight, weight_last,
    input  weight_ready, busy, spike, done, new_potential
  );

  modport slave (
    input  start, has_weights, decayed_potential, threshold, reset_potential,
    input  weight_valid, weight, weight_last,
    output weight_ready, busy, spike, done, new_potential
  );
endinterface

// File: rtl/fp32_add.sv
// Combinational FP32 adder: truncating, denormals flushed to +0, overflow saturated to +/-FP32_MAX.
module fp32_add
  import neuron_pkg::*;
(
  input  logic [FP32_W-1:0] a,
  input  logic [FP32_W-1:0] b,
  output logic [FP32_W-1:0] sum_c
);

  localparam int unsigned MW = FP32_MAN_W + 1;
  localparam int unsigned XW = MW + 3;
  localparam int unsigned SW = XW + 1;

  fp32_t                 a_f;
  fp32_t                 b_f;
  fp32_t                 big_f;
  fp32_t                 sml_f;
  logic [FP32_EXP_W-1:0] diff;
  logic [XW-1:0]         big_x;
  logic [XW-1:0]         sml_x;
  logic [XW-1:0]         sml_sh;
  logic [SW-1:0]         raw;
  logic [SW-1:0]         norm;
  logic [4:0]            lz;
  int                    exp_n;

  always_comb begin
    a_f = fp32_t'(a);
    b_f = fp32_t'(b);
    if ({a_f.exponent, a_f.mantissa} >= {b_f.exponent, b_f.mantissa}) begin
      big_f = a_f;
      sml_f = b_f;
    end else begin
      big_f = b_f;
      sml_f = a_f;
    end

    // Guard/round/sticky bits below the mantissa keep truncation exact for subtraction.
    diff  = big_f.exponent - sml_f.exponent;
    big_x = {1'b1, big_f.mantissa, 3'b000};
    sml_x = {1'b1, sml_f.mantissa, 3'b000};
    if (diff >= FP32_EXP_W'(XW)) begin
      sml_sh = XW'(1);
    end else begin
      sml_sh = (sml_x >> diff) | XW'(|(sml_x & ~({XW{1'b1}} << diff)));
    end

    if (big_f.sign == sml_f.sign) begin
      raw = SW'(big_x) + SW'(sml_sh);
    end else begin
      raw = SW'(big_x) - SW'(sml_sh);
    end

    lz = '0;
    for (int i = 0; i < XW; i++) begin
      if (raw[i]) lz = 5'(XW - 1 - i);
    end

    if (raw[SW-1]) begin
      norm  = {1'b0, raw[SW-1:2], |raw[1:0]};
      exp_n = int'(big_f.exponent) + 1;
    end else begin
      norm  = raw << lz;
      exp_n = int'(big_f.exponent) - int'(lz);
    end

    if (a_f.exponent == '0 && b_f.exponent == '0) begin
      sum_c = FP32_ZERO;
    end else if (b_f.exponent == '0) begin
      sum_c = a;
    end else if (a_f.exponent == '0) begin
      sum_c = b;
    end else if (raw == '0 || exp_n <= 0) begin
      sum_c = FP32_ZERO;
    end else if (exp_n > int'(2 * FP32_BIAS)) begin
      sum_c = {big_f.sign, FP32_MAX[FP32_W-2:0]};
    end else begin
      sum_c = {big_f.sign, FP32_EXP_W'(exp_n), FP32_MAN_W'(norm >> 3)};
    end
  end

endmodule

// File: rtl/membrane_accumulator.sv
// Adds a weight stream onto the decayed membrane potential, compares against threshold,
// and emits spike/done plus the next membrane potential.
module membrane_accumulator
  import neuron_pkg::*;
#(
  parameter bit THRESH_INCLUSIVE = 1'b1
) (
  input  logic                 CLK,
  input  logic                 RESET,
  membrane_accumulator_if.slave bus
);

  acc_state_e        state_q, state_d;
  logic [FP32_W-1:0] acc_q, acc_d;
  logic [FP32_W-1:0] thr_q, thr_d;
  logic [FP32_W-1:0] rst_pot_q, rst_pot_d;
  logic [FP32_W-1:0] new_pot_q, new_pot_d;
  logic              weight_ready_q, weight_ready_d;
  logic              busy_q, busy_d;
  logic              spike_q, spike_d;
  logic              done_q, done_d;
  logic [FP32_W-1:0] add_sum_c;
  logic [FP32_W-2:0] acc_mag, thr_mag;
  logic              mag_eq, acc_gt, fire_c;

  fp32_add u_add (
    .a     (acc_q),
    .b     (bus.weight),
    .sum_c (add_sum_c)
  );

  // Sign-magnitude compare with both zeros treated as equal.
  always_comb begin
    acc_mag = acc_q[FP32_W-2:0];
    thr_mag = thr_q[FP32_W-2:0];
    if (acc_mag == '0 && thr_mag == '0) begin
      mag_eq = 1'b1;
      acc_gt = 1'b0;
    end else if (acc_q[FP32_W-1] != thr_q[FP32_W-1]) begin
      mag_eq = 1'b0;
      acc_gt = ~acc_q[FP32_W-1];
    end else begin
      mag_eq = (acc_mag == thr_mag);
      acc_gt = acc_q[FP32_W-1] ? (acc_mag < thr_mag) : (acc_mag > thr_mag);
    end
    fire_c = acc_gt || (THRESH_INCLUSIVE && mag_eq);
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    thr_d     = thr_q;
    rst_pot_d = rst_pot_q;
    new_pot_d = new_pot_q;
    spike_d   = 1'b0;
    done_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          acc_d     = bus.decayed_potential;
          thr_d     = bus.threshold;
          rst_pot_d = bus.reset_potential;
          state_d   = bus.has_weights ? ST_ACC : ST_CMP;
        end
      end
      ST_ACC: begin
        if (bus.weight_valid) begin
          acc_d = add_sum_c;
          if (bus.weight_last) state_d = ST_CMP;
        end
      end
      ST_CMP: begin
        new_pot_d = fire_c ? rst_pot_q : acc_q;
        spike_d   = fire_c;
        done_d    = 1'b1;
        state_d   = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    weight_ready_d = (state_d == ST_ACC);
    busy_d         = (state_d != ST_IDLE);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q        <= ST_IDLE;
      acc_q          <= FP32_ZERO;
      thr_q          <= FP32_ZERO;
      rst_pot_q      <= FP32_ZERO;
      new_pot_q      <= FP32_ZERO;
      weight_ready_q <= 1'b0;
      busy_q         <= 1'b0;
      spike_q        <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      acc_q          <= acc_d;
      thr_q          <= thr_d;
      rst_pot_q      <= rst_pot_d;
      new_pot_q      <= new_pot_d;
      weight_ready_q <= weight_ready_d;
      busy_q         <= busy_d;
      spike_q        <= spike_d;
      done_q         <= done_d;
    end
  end

  assign bus.weight_ready  = weight_ready_q;
  assign bus.busy          = busy_q;
  assign bus.spike         = spike_q;
  assign bus.done          = done_q;
  assign bus.new_potential = new_pot_q;

endmodule

// File: tb/tb_membrane_accumulator.sv
// Bench for membrane_accumulator: inclusive and exclusive instances share stimulus and are
// checked against an exact-arithmetic FP32 reference.
module tb_membrane_accumulator;
  import neuron_pkg::*;

  typedef logic signed [299:0] big_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] wq[$];
  int          gq[$];

  always #5 clk = ~clk;

  membrane_accumulator_if bus_i ();
  membrane_accumulator_if bus_x ();

  membrane_accumulator #(.THRESH_INCLUSIVE(1'b1)) u_incl (.CLK(clk), .RESET(rst), .bus(bus_i));
  membrane_accumulator #(.THRESH_INCLUSIVE(1'b0)) u_excl (.CLK(clk), .RESET(rst), .bus(bus_x));

  assign bus_x.start             = bus_i.start;
  assign bus_x.has_weights       = bus_i.has_weights;
  assign bus_x.decayed_potential = bus_i.decayed_potential;
  assign bus_x.threshold         = bus_i.threshold;
  assign bus_x.reset_potential   = bus_i.reset_potential;
  assign bus_x.weight_valid      = bus_i.weight_valid;
  assign bus_x.weight            = bus_i.weight;
  assign bus_x.weight_last       = bus_i.weight_last;

  // Reference: FP32 value as an exact integer in units of 2^-149 (denormals read as zero).
  function automatic big_t to_big(input logic [31:0] f);
    big_t m;
    if (f[30:23] == 8'd0) return '0;
    m = big_t'({1'b1, f[22:0]});
    m = m <<< (f[30:23] - 8'd1);
    return f[31] ? -m : m;
  endfunction

  // Exact value truncated toward zero into FP32 with flush and saturation.
  function automatic logic [31:0] from_big(input big_t v);
    logic s;
    big_t m;
    int   p;
    int   e;
    if (v == 0) return FP32_ZERO;
    s = (v < 0);
    m = s ? -v : v;
    p = 0;
    for (int i = 0; i < 300; i++) if (m[i]) p = i;
    e = p - 22;
    if (e <= 0) return FP32_ZERO;
    if (e >= 255) return {s, 31'h7F7FFFFF};
    m = m >> (p - 23);
    return {s, 8'(e), m[22:0]};
  endfunction

  function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b);
    return from_big(to_big(a) + to_big(b));
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [7:0] e = 8'($urandom_range(110, 140));
    return {1'($urandom_range(0, 1)), e, 23'($urandom)};
  endfunction

  // Runs one update starting in the next IDLE cycle; cyc is the cycle done was seen (-1 on timeout).
  task automatic drive_txn(input logic [31:0] dp, input logic [31:0] thr, input logic [31:0] rp,
                           input bit hw, input bit poke, output int cyc, output logic si,
                           output logic sx, output logic [31:0] ni, output logic [31:0] nx,
                           output int bad);
    bad = 0;
    @(posedge clk); #1;
    if (bus_i.busy !== 1'b0 || bus_i.done !== 1'b0) bad++;
    bus_i.start = 1'b1;
    bus_i.has_weights = hw;
    bus_i.decayed_potential = dp;
    bus_i.threshold = thr;
    bus_i.reset_potential = rp;
    cyc = 0;
    @(posedge clk); #1;
    cyc = 1;
    bus_i.start = 1'b0;
    bus_i.decayed_potential = $urandom;
    bus_i.threshold = $urandom;
    bus_i.reset_potential = $urandom;
    if (hw) begin
      for (int k = 0; k < wq.size(); k++) begin
        for (int g = 0; g < gq[k]; g++) begin
          bus_i.weight_valid = 1'b0;
          bus_i.weight = $urandom;
          bus_i.weight_last = 1'($urandom);
          if (bus_i.weight_ready !== 1'b1 || bus_i.busy !== 1'b1) bad++;
          @(posedge clk); #1;
          cyc++;
        end
        bus_i.weight_valid = 1'b1;
        bus_i.weight = wq[k];
        bus_i.weight_last = (k == wq.size() - 1);
        if (poke && k == 0) begin
          bus_i.start = 1'b1;
          bus_i.has_weights = 1'b0;
          bus_i.decayed_potential = rand_fp();
        end
        if (bus_i.weight_ready !== 1'b1 || bus_i.busy !== 1'b1) bad++;
        @(posedge clk); #1;
        cyc++;
        bus_i.start = 1'b0;
      end
      bus_i.weight_valid = 1'b0;
      bus_i.weight_last = 1'b0;
    end
    while (bus_i.done !== 1'b1 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (bus_i.done !== 1'b1) cyc = -1;
    if (bus_x.done !== bus_i.done) bad++;
    si = bus_i.spike;
    sx = bus_x.spike;
    ni = bus_i.new_potential;
    nx = bus_x.new_potential;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus_i.start = 1'b0;
    bus_i.has_weights = 1'b0;
    bus_i.decayed_potential = '0;
    bus_i.threshold = '0;
    bus_i.reset_potential = '0;
    bus_i.weight_valid = 1'b0;
    bus_i.weight = '0;
    bus_i.weight_last = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus_i.weight_ready, bus_i.busy, bus_i.spike, bus_i.done} !== 4'b0000) begin
      errors++; $display("FAIL reset_ctrl_incl got %b want 0000", {bus_i.weight_ready, bus_i.busy, bus_i.spike, bus_i.done});
    end
    checks++;
    if ({bus_x.weight_ready, bus_x.busy, bus_x.spike, bus_x.done} !== 4'b0000) begin
      errors++; $display("FAIL reset_ctrl_excl got %b want 0000", {bus_x.weight_ready, bus_x.busy, bus_x.spike, bus_x.done});
    end
    checks++;
    if (bus_i.new_potential !== FP32_ZERO) begin
      errors++; $display("FAIL reset_np_incl got %h want 00000000", bus_i.new_potential);
    end
    checks++;
    if (bus_x.new_potential !== FP32_ZERO) begin
      errors++; $display("FAIL reset_np_excl got %h want 00000000", bus_x.new_potential);
    end
    rst = 1'b0;
  endtask

  task automatic test_fire();
    int cyc, bad; logic si, sx; logic [31:0] ni, nx;
    wq = '{32'h40000000, 32'h40400000}; gq = '{0, 0};
    drive_txn(32'h41200000, 32'h41700000, FP32_ZERO, 1'b1, 1'b0, cyc, si, sx, ni, nx, bad);
    checks++; if (cyc !== 4) begin errors++; $display("FAIL fire_cycle got %0d want 4", cyc); end
    checks++; if ({si, ni} !== {1'b1, 32'h00000000}) begin errors++; $display("FAIL fire_incl got %b/%h want 1/00000000", si, ni); end
    checks++; if ({sx, nx} !== {1'b0, 32'h41700000}) begin errors++; $display("FAIL fire_excl got %b/%h want 0/41700000", sx, nx); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL fire_protocol got %0d want 0", bad); end
  endtask

  task automatic test_sub_threshold();
    int cyc, bad; logic si, sx; logic [31:0] ni, nx;
    wq = '{32'h40000000, 32'h40400000}; gq = '{0, 0};
    drive_txn(32'h41200000, 32'h41800000, FP32_ZERO, 1'b1, 1'b0, cyc, si, sx, ni, nx, bad);
    checks++; if (cyc !== 4) begin errors++; $display("FAIL sub_cycle got %0d want 4", cyc); end
    checks++; if ({si, ni} !== {1'b0, 32'h41700000}) begin errors++; $display("FAIL sub_incl got %b/%h want 0/41700000", si, ni); end
    checks++; if ({sx, nx} !== {1'b0, 32'h41700000}) begin errors++; $display("FAIL sub_excl got %b/%h want 0/41700000", sx, nx); end
  endtask

  task automatic test_negative_weight();
    int cyc, bad; logic si, sx; logic [31:0] ni, nx;
    wq = '{32'hC1400000}; gq = '{0};
    drive_txn(32'h41200000, 32'h41700000, FP32_ONE, 1'b1, 1'b0, cyc, si, sx, ni, nx, bad);
    checks++; if (cyc !== 3) begin errors++; $display("FAIL neg_cycle got %0d want 3", cyc); end
    checks++; if ({si, ni} !== {1'b0, 32'hC0000000}) begin errors++; $display("FAIL neg_incl got %b/%h want 0/c0000000", si, ni); end
    checks++; if ({sx, nx} !== {1'b0, 32'hC0000000}) begin errors++; $display("FAIL neg_excl got %b/%h want 0/c0000000", sx, nx); end
  endtask

  task automatic test_no_weights();
    int cyc, bad; logic si, sx; logic [31:0] ni, nx;
    wq = {}; gq = {};
    drive_txn(32'h41200000, 32'h41700000, FP32_ZERO, 1'b0, 1'b0, cyc, si, sx, ni, nx, bad);
    checks++; if (cyc !== 2) begin errors++; $display("FAIL nowt_cycle got %0d want 2", cyc); end
    checks++; if ({si, ni} !== {1'b0, 32'h41200000}) begin errors++; $display("FAIL nowt_incl got %b/%h want 0/41200000", si, ni); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL nowt_protocol got %0d want 0", bad); end
  endtask

  task automatic test_backpressure();
    int cyc, bad; logic si, sx; logic [31:0] ni, nx;
    wq = '{32'h40000000, 32'h40400000, FP32_ONE}; gq = '{0, 0, 0};
    drive_txn(32'h41200000, 32'h41800000, FP32_ZERO, 1'b1, 1'b0, cyc, si, sx, ni, nx, bad);
    checks++; if (cyc !== 5) begin errors++; $display("FAIL bp_nogap_cycle got %0d want 5", cyc); end
    checks++; if ({sx, nx} !== {1'b0, 32'h41800000}) begin errors++; $display("FAIL bp_nogap_excl got %b/%h want 0/41800000", sx, nx); end
    gq = '{0, 1, 1};
    drive_txn(32'h41200000, 32'h41800000, FP32_ZERO, 1'b1, 1'b0, cyc, si, sx, ni, nx, bad);
    checks++; if (cyc !== 7) begin errors++; $display("FAIL bp_gap_cycle got %0d want 7", cyc); end
    checks++; if ({si, ni} !== {1'b1, 32'h00000000}) begin errors++; $display("FAIL bp_gap_incl got %b/%h want 1/00000000", si, ni); end
    checks++; if ({sx, nx} !== {1'b0, 32'h41800000}) begin errors++; $display("FAIL bp_gap_excl got %b/%h want 0/41800000", sx, nx); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL bp_protocol got %0d want 0", bad); end
  endtask

  task automatic test_ignored_start();
    int cyc, bad; logic si, sx; logic [31:0] ni, nx;
    wq = '{32'h40000000, 32'h40400000}; gq = '{1, 0};
    drive_txn(32'h41200000, 32'h41800000, FP32_ZERO, 1'b1, 1'b1, cyc, si, sx, ni, nx, bad);
    checks++; if (cyc !== 5) begin errors++; $display("FAIL poke_cycle got %0d want 5", cyc); end
    checks++; if ({si, ni} !== {1'b0, 32'h41700000}) begin errors++; $display("FAIL poke_incl got %b/%h want 0/41700000", si, ni); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL poke_protocol got %0d want 0", bad); end
  endtask

  task automatic test_saturate();
    int cyc, bad; logic si, sx; logic [31:0] ni, nx;
    wq = '{FP32_MAX}; gq = '{0};
    drive_txn(FP32_MAX, FP32_MAX, FP32_ONE, 1'b1, 1'b0, cyc, si, sx, ni, nx, bad);
    checks++; if ({si, ni} !== {1'b1, FP32_ONE}) begin errors++; $display("FAIL sat_incl got %b/%h want 1/3f800000", si, ni); end
    checks++; if ({sx, nx} !== {1'b0, FP32_MAX}) begin errors++; $display("FAIL sat_excl got %b/%h want 0/7f7fffff", sx, nx); end
    wq = '{32'hFF7FFFFF}; gq = '{0};
    drive_txn(32'hFF7FFFFF, FP32_ZERO, FP32_ONE, 1'b1, 1'b0, cyc, si, sx, ni, nx, bad);
    checks++; if ({sx, nx} !== {1'b0, 32'hFF7FFFFF}) begin errors++; $display("FAIL sat_neg got %b/%h want 0/ff7fffff", sx, nx); end
  endtask

  task automatic test_cancel();
    int cyc, bad; logic si, sx; logic [31:0] ni, nx;
    wq = '{32'hBF800000}; gq = '{0};
    drive_txn(FP32_ONE, FP32_ONE, FP32_MAX, 1'b1, 1'b0, cyc, si, sx, ni, nx, bad);
    checks++; if ({si, ni} !== {1'b0, FP32_ZERO}) begin errors++; $display("FAIL cancel_incl got %b/%h want 0/00000000", si, ni); end
    drive_txn(FP32_ONE, 32'h80000000, FP32_MAX, 1'b1, 1'b0, cyc, si, sx, ni, nx, bad);
    checks++; if ({si, ni} !== {1'b1, FP32_MAX}) begin errors++; $display("FAIL negzero_incl got %b/%h want 1/7f7fffff", si, ni); end
    checks++; if ({sx, nx} !== {1'b0, FP32_ZERO}) begin errors++; $display("FAIL negzero_excl got %b/%h want 0/00000000", sx, nx); end
  endtask

  task automatic test_random();
    int cyc, bad, n, gaps, e_cyc; logic si, sx, e_si, e_sx; bit hw, poke;
    logic [31:0] ni, nx, dp, thr, rp, acc;
    for (int t = 0; t < 40; t++) begin
      n = $urandom_range(0, 5);
      hw = (n != 0);
      dp = rand_fp();
      rp = rand_fp();
      wq = {}; gq = {};
      gaps = 0;
      acc = dp;
      for (int k = 0; k < n; k++) begin
        wq.push_back(rand_fp());
        gq.push_back($urandom_range(0, 2));
        gaps += gq[k];
        acc = ref_add(acc, wq[k]);
      end
      case ($urandom_range(0, 2))
        0: thr = (acc == FP32_ZERO) ? rand_fp() : acc;
        1: thr = rand_fp();
        default: thr = (acc == FP32_ZERO) ? FP32_ONE : {acc[31], acc[30:0] + 31'd1};
      endcase
      poke = hw && ($urandom_range(0, 3) == 0);
      e_si = (to_big(acc) >= to_big(thr));
      e_sx = (to_big(acc) > to_big(thr));
      e_cyc = hw ? 2 + n + gaps : 2;
      drive_txn(dp, thr, rp, hw, poke, cyc, si, sx, ni, nx, bad);
      checks++; if (cyc !== e_cyc) begin errors++; $display("FAIL rand%0d_cycle got %0d want %0d", t, cyc, e_cyc); end
      checks++; if ({si, ni} !== {e_si, e_si ? rp : acc}) begin errors++; $display("FAIL rand%0d_incl got %b/%h want %b/%h", t, si, ni, e_si, e_si ? rp : acc); end
      checks++; if ({sx, nx} !== {e_sx, e_sx ? rp : acc}) begin errors++; $display("FAIL rand%0d_excl got %b/%h want %b/%h", t, sx, nx, e_sx, e_sx ? rp : acc); end
      checks++; if (bad !== 0) begin errors++; $display("FAIL rand%0d_protocol got %0d want 0", t, bad); end
    end
  endtask

  task automatic test_back_to_back();
    int cyc, bad; logic si, sx; logic [31:0] ni, nx;
    wq = {}; gq = {};
    drive_txn(32'h41200000, 32'h41200000, FP32_ONE, 1'b0, 1'b0, cyc, si, sx, ni, nx, bad);
    checks++; if ({cyc, si, ni} !== {32'd2, 1'b1, FP32_ONE}) begin errors++; $display("FAIL b2b_first got %0d/%b/%h want 2/1/3f800000", cyc, si, ni); end
    wq = '{32'h40000000, 32'h40400000}; gq = '{0, 0};
    drive_txn(32'h41200000, 32'h41800000, FP32_ZERO, 1'b1, 1'b0, cyc, si, sx, ni, nx, bad);
    checks++; if ({cyc, si, ni} !== {32'd4, 1'b0, 32'h41700000}) begin errors++; $display("FAIL b2b_second got %0d/%b/%h want 4/0/41700000", cyc, si, ni); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL b2b_protocol got %0d want 0", bad); end
  endtask

  task automatic test_reset_mid_acc();
    int seen;
    @(posedge clk); #1;
    bus_i.start = 1'b1;
    bus_i.has_weights = 1'b1;
    bus_i.decayed_potential = 32'h41200000;
    bus_i.threshold = 32'h41700000;
    bus_i.reset_potential = FP32_ONE;
    @(posedge clk); #1;
    bus_i.start = 1'b0;
    bus_i.weight_valid = 1'b1;
    bus_i.weight = 32'h40000000;
    bus_i.weight_last = 1'b0;
    @(posedge clk); #1;
    checks++; if (bus_i.busy !== 1'b1) begin errors++; $display("FAIL midrst_pre_busy got %b want 1", bus_i.busy); end
    #2 rst = 1'b1;
    #1;
    checks++; if ({bus_i.busy, bus_i.weight_ready, bus_x.busy} !== 3'b000) begin errors++; $display("FAIL midrst_busy got %b want 000", {bus_i.busy, bus_i.weight_ready, bus_x.busy}); end
    @(posedge clk); #1;
    rst = 1'b0;
    bus_i.weight_valid = 1'b1;
    bus_i.weight_last = 1'b1;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      if (bus_i.done || bus_i.spike || bus_x.done || bus_x.spike || bus_i.busy) seen++;
      @(posedge clk); #1;
    end
    bus_i.weight_valid = 1'b0;
    bus_i.weight_last = 1'b0;
    checks++; if (seen !== 0) begin errors++; $display("FAIL midrst_activity got %0d want 0", seen); end
    checks++; if ({bus_i.new_potential, bus_x.new_potential} !== 64'd0) begin errors++; $display("FAIL midrst_np got %h/%h want 0/0", bus_i.new_potential, bus_x.new_potential); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_fire();
    test_sub_threshold();
    test_negative_weight();
    test_no_weights();
    test_backpressure();
    test_ignored_start();
    test_saturate();
    test_cancel();
    test_random();
    test_back_to_back();
    test_reset_mid_acc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/membrane_accumulator.md
# membrane_accumulator

Downstream stage of `potential_decay` in the neuron datapath. Takes the decayed FP32 membrane potential, adds a stream of FP32 synaptic weights, one per cycle, under a valid/ready handshake, and compares the sum against the firing threshold. On completion it emits a one-cycle `spike` and the next membrane potential. That potential is either the reset value or the accumulated sum, and is fed back to `potential_decay` for the next timestep.

## Interface
- `THRESH_INCLUSIVE`, default 1: 1 fires when sum >= threshold; 0 fires when sum > threshold.

- `CLK`  in  1  single clock; all state updates on the rising edge.
- `RESET`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin an update; sampled only in IDLE.
- `has_weights`  in  1  sampled with `start`; 0 skips accumulation.
- `decayed_potential`  in  32  FP32 output of `potential_decay`; sampled with `start`.
- `threshold`  in  32  FP32 firing threshold; sampled with `start`.
- `reset_potential`  in  32  FP32 post-spike value; sampled with `start`.
- `weight_valid`  in  1  a weight is presented.
- `weight`  in  32  FP32 synaptic weight.
- `weight_last`  in  1  qualifies the final weight of the timestep.
- `weight_ready`  out  1  high only in ACC.
- `busy`  out  1  high in every state except IDLE.
- `spike`  out  1  one-cycle pulse in DONE when the neuron fires.
- `done`  out  1  one-cycle pulse in DONE.
- `new_potential`  out  32  registered; updated on entry to DONE and held until the next DONE.

## Operation
- FSM states: IDLE, ACC, CMP, DONE.
  - IDLE: if `start`, latch the inputs and set acc = `decayed_potential`. Go to ACC if `has_weights`, else to CMP.
  - ACC: on `weight_valid && weight_ready`, set acc = acc + `weight`. If `weight_last` is also set, go to CMP. With no valid weight, stay in ACC with acc unchanged.
  - CMP: set fire = (acc >= thr) or (acc > thr), per `THRESH_INCLUSIVE`. Then `new_potential` = fire ? reset_potential : acc. Go to DONE.
  - DONE: `done` = 1 and `spike` = fire. Return to IDLE.
- `start` outside IDLE is ignored.
- FP32 add rules (combinational):
  - Align the smaller operand, then add or subtract magnitudes and normalize.
  - Rounding truncates toward zero.
  - Denormal inputs and results flush to +0; an exact cancellation gives +0.
  - Overflow saturates to ±0x7F7FFFFF.
  - NaN and Inf inputs are out of contract.
- FP32 compare: sign-magnitude, with -0 equal to +0.

## Timing
- Reset values: state IDLE; `weight_ready`, `busy`, `spike` and `done` are 0; `new_potential` is 0x00000000; internal registers are 0.
- `start` at cycle 0 moves the FSM to ACC at cycle 1.
- With N weights accepted back-to-back, the last is accepted at cycle N. CMP is cycle N+1 and DONE is cycle N+2.
- With `has_weights` = 0, CMP is cycle 1 and DONE is cycle 2.
- Each cycle with `weight_valid` low in ACC adds one cycle of latency.
- Throughput is one accepted weight per cycle.
- A back-to-back `start` is accepted in the IDLE cycle right after DONE.
- Asserting `RESET` in any state returns the FSM to IDLE immediately. Any partial sum is discarded, and `done` and `spike` do not fire.

## Structure
- Shared package `neuron_pkg` holds:
  - state encoding;
  - FP32 field widths (sign 1, exponent 8, mantissa 23) and the exponent bias 127;
  - constants `FP32_ZERO` = 0x00000000, `FP32_MAX` = 0x7F7FFFFF, and `FP32_ONE` = 0x3F800000.
- One sub-module, `fp32_add`: combinational add under the rules above, reusable by other neuron stages.
- The compare logic stays inline in the top level.

## Test plan
- Firing, inclusive: `decayed_potential` 0x41200000 (10.0), weights 0x40000000 (2.0) and 0x40400000 (3.0, last), threshold 0x41700000 (15.0), `reset_potential` 0. Expect `spike` and `done` at cycle 4 and `new_potential` 0x00000000. With `THRESH_INCLUSIVE` = 0, expect no spike and 0x41700000.
- Sub-threshold: same stimulus with threshold 0x41800000 (16.0). Expect no spike, `new_potential` 0x41700000, `done` at cycle 4.
- Negative weight and zero-weight path:
  - 10.0 + 0xC1400000 (-12.0) gives `new_potential` 0xC0000000 (-2.0) with no spike.
  - `has_weights` = 0 with 10.0 gives `done` at cycle 2 and `new_potential` 0x41200000.
- Backpressure and ignored start:
  - 1-cycle `weight_valid` gaps between three weights each add one cycle to `done` latency, and the sum is unchanged.
  - `start` pulsed during ACC has no effect.
- Boundaries:
  - 0x7F7FFFFF + 0x7F7FFFFF saturates to 0x7F7FFFFF.
  - 1.0 + (-1.0) gives +0.
  - `RESET` asserted mid-ACC: `busy` drops immediately, no `done` pulse, `new_potential` reads 0x00000000.
